// File: rtl/pc_fetch_gen_pkg.sv
// Shared select encodings and fetch FSM states for the next-PC / fetch path.
package pc_fetch_gen_pkg;
  localparam logic A_4   = 1'b0;
  localparam logic A_IMM = 1'b1;
  localparam logic B_PC  = 1'b0;
  localparam logic B_RS1 = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_HOLD,
    ST_HALT
  } fetch_state_e;
endpackage

// File: rtl/pc_fetch_gen_pc_target.sv
// Redirect target: (imm|4) + (rs1|ex_pc), JALR bit-0 clear, misalign detect.
module pc_target
  import pc_fetch_gen_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            a_sel_i,
  input  logic            b_sel_i,
  input  logic [XLEN-1:0] ex_pc_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [XLEN-1:0] rs1_i,
  output logic [XLEN-1:0] target_o,
  output logic            misalign_o
);
  logic [XLEN-1:0] addend, base;

  always_comb begin
    addend   = (a_sel_i == A_IMM) ? imm_i : XLEN'(4);
    base     = (b_sel_i == B_RS1) ? rs1_i : ex_pc_i;
    target_o = addend + base;
    if (b_sel_i == B_RS1) target_o[0] = 1'b0;
    misalign_o = |target_o[1:0];
  end
endmodule

// File: rtl/pc_fetch_gen.sv
// Fetch PC register, single-outstanding fetch FSM and one-entry decode buffer.
module pc_fetch_gen
  import pc_fetch_gen_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            PCAsrc,
  input  logic            PCBsrc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1,
  input  logic            stall,
  output logic            if_req_valid,
  output logic [XLEN-1:0] if_req_addr,
  input  logic            if_req_ready,
  input  logic            if_rsp_valid,
  input  logic [31:0]     if_rsp_inst,
  output logic            id_valid,
  output logic [31:0]     id_inst,
  output logic [XLEN-1:0] id_pc,
  output logic            misalign
);
  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, id_pc_q, id_pc_d;
  logic [31:0]     id_inst_q, id_inst_d;
  logic            kill_q, kill_d, id_valid_q, id_valid_d, mis_q, mis_d;
  logic [XLEN-1:0] tgt;
  logic            tgt_mis, redir;

  pc_target #(.XLEN(XLEN)) u_tgt (
    .a_sel_i(PCAsrc), .b_sel_i(PCBsrc), .ex_pc_i(ex_pc), .imm_i(imm),
    .rs1_i(rs1), .target_o(tgt), .misalign_o(tgt_mis)
  );

  assign redir = redirect_valid && (state_q != ST_HALT);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    kill_d     = kill_q;
    id_valid_d = id_valid_q;
    id_inst_d  = id_inst_q;
    id_pc_d    = id_pc_q;
    mis_d      = mis_q;
    if (id_valid_q && !stall) id_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: state_d = ST_REQ;
      ST_REQ:  if (if_req_ready) state_d = ST_WAIT;
      ST_WAIT: begin
        if (if_rsp_valid) begin
          state_d = ST_REQ;
          if (kill_q) begin
            kill_d = 1'b0;
          end else begin
            id_valid_d = 1'b1;
            id_inst_d  = if_rsp_inst;
            id_pc_d    = pc_q;
            pc_d       = pc_q + XLEN'(4);
            if (id_valid_q && stall) state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: if (!stall) state_d = ST_REQ;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
    // Redirect overrides stall and any same-cycle response; the buffer is flushed.
    if (redir) begin
      pc_d       = tgt;
      id_valid_d = 1'b0;
      id_inst_d  = id_inst_q;
      id_pc_d    = id_pc_q;
      state_d    = ST_REQ;
      if (state_q == ST_REQ && if_req_ready) begin
        kill_d  = 1'b1;
        state_d = ST_WAIT;
      end else if (state_q == ST_WAIT && !if_rsp_valid) begin
        kill_d  = 1'b1;
        state_d = ST_WAIT;
      end else if (state_q == ST_WAIT) begin
        kill_d = 1'b0;
      end
      if (tgt_mis) begin
        mis_d   = 1'b1;
        kill_d  = 1'b0;
        state_d = ST_HALT;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      kill_q     <= 1'b0;
      id_valid_q <= 1'b0;
      id_inst_q  <= '0;
      id_pc_q    <= '0;
      mis_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      kill_q     <= kill_d;
      id_valid_q <= id_valid_d;
      id_inst_q  <= id_inst_d;
      id_pc_q    <= id_pc_d;
      mis_q      <= mis_d;
    end
  end

  assign if_req_valid = (state_q == ST_REQ);
  assign if_req_addr  = pc_q;
  assign id_valid     = id_valid_q;
  assign id_inst      = id_inst_q;
  assign id_pc        = id_pc_q;
  assign misalign     = mis_q;
endmodule

// File: tb/tb_pc_fetch_gen.sv
// Scoreboarded bench: expected fetch addresses queued, checked as requests are accepted.
module tb_pc_fetch_gen;
  localparam int XLEN = 64;
  localparam logic [63:0] RST_PC = 64'h8000_0000;

  logic            clk = 1'b0;
  logic            rst;
  logic            PCAsrc, PCBsrc, redirect_valid, stall;
  logic [XLEN-1:0] ex_pc, imm, rs1;
  logic            if_req_valid, if_req_ready, if_rsp_valid;
  logic [XLEN-1:0] if_req_addr;
  logic [31:0]     if_rsp_inst, id_inst;
  logic            id_valid, misalign;
  logic [XLEN-1:0] id_pc;

  int n_vec = 0, n_err = 0;
  logic [63:0] exp_q[$];
  int          lat = 1, cnt = 0, drop_n = 0;
  logic        pend = 1'b0, rsp_keep = 1'b0;
  logic [63:0] pend_addr = '0, rsp_addr = '0;

  always #5 clk = ~clk;

  pc_fetch_gen #(.XLEN(XLEN), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .PCAsrc(PCAsrc), .PCBsrc(PCBsrc),
    .redirect_valid(redirect_valid), .ex_pc(ex_pc), .imm(imm), .rs1(rs1),
    .stall(stall), .if_req_valid(if_req_valid), .if_req_addr(if_req_addr),
    .if_req_ready(if_req_ready), .if_rsp_valid(if_rsp_valid),
    .if_rsp_inst(if_rsp_inst), .id_valid(id_valid), .id_inst(id_inst),
    .id_pc(id_pc), .misalign(misalign)
  );

  function automatic logic [31:0] mk(input logic [63:0] a);
    return a[31:0] ^ 32'h5A5A_0013;
  endfunction

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  // One clock: accept/verify requests, model memory latency, verify buffer loads.
  task automatic tick();
    logic acc, ld;
    logic [63:0] a, e;
    acc = if_req_valid && if_req_ready;
    a   = if_req_addr;
    ld  = if_rsp_valid && rsp_keep && !redirect_valid && !rst;
    @(posedge clk); #1;
    if_rsp_valid = 1'b0;
    rsp_keep     = 1'b0;
    if (ld) begin
      chk("id_valid_ld", {63'd0, id_valid}, 64'd1);
      chk("id_pc", id_pc, rsp_addr);
      chk("id_inst", {32'd0, id_inst}, {32'd0, mk(rsp_addr)});
    end
    if (acc) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
      chk("req_addr", a, e);
      pend = 1'b1; pend_addr = a; cnt = lat;
    end
    if (pend) begin
      cnt--;
      if (cnt <= 0) begin
        pend = 1'b0;
        if_rsp_valid = 1'b1;
        if_rsp_inst  = mk(pend_addr);
        rsp_addr     = pend_addr;
        rsp_keep     = (drop_n == 0);
        if (drop_n > 0) drop_n--;
      end
    end
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while (exp_q.size() != 0 && n < bound) begin tick(); n++; end
    chk("drain", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic redirect(input logic a, input logic b, input logic [63:0] pc,
                          input logic [63:0] im, input logic [63:0] r);
    PCAsrc = a; PCBsrc = b; ex_pc = pc; imm = im; rs1 = r; redirect_valid = 1'b1;
    tick();
    redirect_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; PCAsrc = 0; PCBsrc = 0; redirect_valid = 0; stall = 0;
    ex_pc = '0; imm = '0; rs1 = '0; if_req_ready = 1'b1;
    if_rsp_valid = 1'b0; if_rsp_inst = '0;
    repeat (3) tick();
    chk("rst_req_valid", {63'd0, if_req_valid}, 64'd0);
    chk("rst_req_addr", if_req_addr, RST_PC);
    chk("rst_id_valid", {63'd0, id_valid}, 64'd0);
    chk("rst_id_inst", {32'd0, id_inst}, 64'd0);
    chk("rst_id_pc", id_pc, 64'd0);
    chk("rst_misalign", {63'd0, misalign}, 64'd0);

    // Sequential fetch, 1-cycle memory
    rst = 1'b0;
    chk("idle_no_req", {63'd0, if_req_valid}, 64'd0);
    tick();
    chk("first_req", {63'd0, if_req_valid}, 64'd1);
    exp_q.push_back(64'h8000_0000);
    exp_q.push_back(64'h8000_0004);
    exp_q.push_back(64'h8000_0008);
    drain(40);
    if_req_ready = 1'b0;
    tick(); tick();
    chk("seq_park_addr", if_req_addr, 64'h8000_000C);

    // JAL while request not accepted
    redirect(1'b1, 1'b0, 64'h8000_0010, 64'h20, 64'h0);
    chk("jal_valid", {63'd0, if_req_valid}, 64'd1);
    chk("jal_addr", if_req_addr, 64'h8000_0030);

    // JALR while waiting on a slow response: that response must be dropped
    lat = 3;
    exp_q.push_back(64'h8000_0030);
    if_req_ready = 1'b1;
    tick();
    if_req_ready = 1'b0;
    drop_n = 1;
    redirect(1'b1, 1'b1, 64'h8000_0030, 64'h0, 64'h8000_1001);
    tick(); tick();
    chk("jalr_valid", {63'd0, if_req_valid}, 64'd1);
    chk("jalr_addr", if_req_addr, 64'h8000_1000);
    chk("jalr_id_valid", {63'd0, id_valid}, 64'd0);

    // Stall with full buffer -> HOLD
    lat = 1; stall = 1'b1; if_req_ready = 1'b1;
    exp_q.push_back(64'h8000_1000);
    exp_q.push_back(64'h8000_1004);
    drain(40);
    if_req_ready = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_no_req", {63'd0, if_req_valid}, 64'd0);
      chk("hold_inst", {32'd0, id_inst}, {32'd0, mk(64'h8000_1004)});
      chk("hold_id_valid", {63'd0, id_valid}, 64'd1);
    end
    stall = 1'b0;
    tick();
    chk("unhold_valid", {63'd0, if_req_valid}, 64'd1);
    chk("unhold_addr", if_req_addr, 64'h8000_1008);
    chk("unhold_consumed", {63'd0, id_valid}, 64'd0);

    // Redirect (not-taken, ex_pc+4) on the same cycle as a response
    exp_q.push_back(64'h8000_1008);
    if_req_ready = 1'b1;
    tick();
    if_req_ready = 1'b0;
    chk("coll_rsp_present", {63'd0, if_rsp_valid}, 64'd1);
    redirect(1'b0, 1'b0, 64'h8000_2000, 64'h0, 64'h0);
    chk("coll_id_valid", {63'd0, id_valid}, 64'd0);
    chk("coll_valid", {63'd0, if_req_valid}, 64'd1);
    chk("coll_addr", if_req_addr, 64'h8000_2004);

    // Misaligned target halts fetch
    redirect(1'b1, 1'b0, 64'h8000_0000, 64'h102, 64'h0);
    chk("mis_flag", {63'd0, misalign}, 64'd1);
    chk("mis_no_req", {63'd0, if_req_valid}, 64'd0);
    chk("mis_id_valid", {63'd0, id_valid}, 64'd0);
    if_req_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("halt_no_req", {63'd0, if_req_valid}, 64'd0);
      chk("halt_sticky", {63'd0, misalign}, 64'd1);
    end

    // Asynchronous reset, then a stray response during IDLE
    if_req_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("arst_misalign", {63'd0, misalign}, 64'd0);
    chk("arst_req_addr", if_req_addr, RST_PC);
    chk("arst_id_pc", id_pc, 64'd0);
    pend = 1'b0;
    tick();
    rst = 1'b0;
    if_rsp_valid = 1'b1; if_rsp_inst = 32'h1234_5678; rsp_keep = 1'b0;
    tick();
    chk("idle_rsp_ignored", {63'd0, id_valid}, 64'd0);
    chk("post_rst_valid", {63'd0, if_req_valid}, 64'd1);
    chk("post_rst_addr", if_req_addr, RST_PC);
    chk("final_q_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
